// File: rtl/axis_switch_mxn.sv
// axis_switch_mxn: packet-level AXI-Stream crossbar with NUM_IN slave streams and
// NUM_OUT master streams, routed by tdest. Each output has its own round-robin
// arbiter; a grant is held until the granted packet's tlast handshake. Packets
// addressed to tdest >= NUM_OUT are accepted and discarded.
// Optional feature: define AXIS_SWITCH_DROP_CNT_EN to add a 16-bit saturating
// drop_count output counting discarded packets.
module axis_switch_mxn #(
    parameter int unsigned AXIS_BYTES      = 1,
    parameter int unsigned AXIS_TDEST_BITS = 4,
    parameter int unsigned NUM_IN          = 2,
    parameter int unsigned NUM_OUT         = 4
) (
    input  logic                                   clk,
    input  logic                                   sresetn,
    output logic [NUM_IN-1:0]                      axis_i_tready,
    input  logic [NUM_IN-1:0]                      axis_i_tvalid,
    input  logic [NUM_IN-1:0]                      axis_i_tlast,
    input  logic [NUM_IN*AXIS_TDEST_BITS-1:0]      axis_i_tdest,
    input  logic [NUM_IN*AXIS_BYTES*8-1:0]         axis_i_tdata,
    input  logic [NUM_OUT-1:0]                     axis_o_tready,
    output logic [NUM_OUT-1:0]                     axis_o_tvalid,
    output logic [NUM_OUT-1:0]                     axis_o_tlast,
    output logic [NUM_OUT*AXIS_TDEST_BITS-1:0]     axis_o_tdest,
    output logic [NUM_OUT*AXIS_BYTES*8-1:0]        axis_o_tdata
`ifdef AXIS_SWITCH_DROP_CNT_EN
    ,
    output logic [15:0]                            drop_count
`endif
);

    localparam int unsigned DW = AXIS_BYTES * 8;
    localparam int unsigned TW = AXIS_TDEST_BITS;
    localparam int unsigned GW = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;

    // Per-input state encoding
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_DROP = 1'b1;

    // Per-output arbitration state
    logic [NUM_OUT-1:0] lock_q, lock_d;
    logic [GW-1:0]      gnt_q [NUM_OUT];
    logic [GW-1:0]      gnt_d [NUM_OUT];
    logic [GW-1:0]      rr_q  [NUM_OUT];
    logic [GW-1:0]      rr_d  [NUM_OUT];

    // Per-input drop state
    logic [0:0]         st_q  [NUM_IN];
    logic [0:0]         st_d  [NUM_IN];

    // Derived per-input / per-output conditions
    logic [NUM_IN-1:0]  busy;        // input currently owns some output
    logic [NUM_IN-1:0]  misroute;    // tdest addresses no existing output
    logic [NUM_IN-1:0]  drop_fire;   // last beat of a discarded packet accepted
    logic [NUM_IN-1:0]  req [NUM_OUT];
    logic [NUM_OUT-1:0] win_vld;
    logic [GW-1:0]      win_idx [NUM_OUT];

    // Which inputs are currently held by a locked output
    always_comb begin
        busy = '0;
        for (int unsigned j = 0; j < NUM_OUT; j++) begin
            for (int unsigned k = 0; k < NUM_IN; k++) begin
                if (lock_q[j] && (gnt_q[j] == GW'(k))) begin
                    busy[k] = 1'b1;
                end
            end
        end
    end

    // Decode tdest of every input into per-output requests and drop conditions
    always_comb begin
        misroute  = '0;
        drop_fire = '0;
        for (int unsigned j = 0; j < NUM_OUT; j++) begin
            req[j] = '0;
        end
        for (int unsigned k = 0; k < NUM_IN; k++) begin
            misroute[k]  = (32'(axis_i_tdest[k*TW +: TW]) >= NUM_OUT);
            drop_fire[k] = (st_q[k] == ST_DROP) && axis_i_tvalid[k] && axis_i_tlast[k];
            for (int unsigned j = 0; j < NUM_OUT; j++) begin
                req[j][k] = (st_q[k] == ST_IDLE) && axis_i_tvalid[k] && !busy[k] &&
                            (32'(axis_i_tdest[k*TW +: TW]) == j);
            end
        end
    end

    // Round-robin pick per output: first requester after the last winner
    always_comb begin
        win_vld = '0;
        for (int unsigned j = 0; j < NUM_OUT; j++) begin
            win_idx[j] = '0;
        end
        for (int unsigned j = 0; j < NUM_OUT; j++) begin
            for (int unsigned i = 1; i <= NUM_IN; i++) begin
                for (int unsigned k = 0; k < NUM_IN; k++) begin
                    if (!win_vld[j] && req[j][k] &&
                        (k == (32'(rr_q[j]) + i) % NUM_IN)) begin
                        win_vld[j] = 1'b1;
                        win_idx[j] = GW'(k);
                    end
                end
            end
        end
    end

    // Datapath: locked outputs pass the granted input straight through
    always_comb begin
        axis_o_tvalid = '0;
        axis_o_tlast  = '0;
        axis_o_tdest  = '0;
        axis_o_tdata  = '0;
        axis_i_tready = '0;
        if (sresetn) begin
            for (int unsigned k = 0; k < NUM_IN; k++) begin
                if (st_q[k] == ST_DROP) begin
                    axis_i_tready[k] = 1'b1;
                end
            end
            for (int unsigned j = 0; j < NUM_OUT; j++) begin
                for (int unsigned k = 0; k < NUM_IN; k++) begin
                    if (lock_q[j] && (gnt_q[j] == GW'(k))) begin
                        axis_o_tvalid[j]           = axis_i_tvalid[k];
                        axis_o_tlast[j]            = axis_i_tlast[k];
                        axis_o_tdest[j*TW +: TW]   = axis_i_tdest[k*TW +: TW];
                        axis_o_tdata[j*DW +: DW]   = axis_i_tdata[k*DW +: DW];
                        axis_i_tready[k]           = axis_o_tready[j];
                    end
                end
            end
        end
    end

    // Next-state for locks, grants, round-robin pointers and drop states.
    // A release leaves lock low for one cycle, so arbitration for the next
    // packet only happens in that bubble cycle.
    always_comb begin
        lock_d = lock_q;
        gnt_d  = gnt_q;
        rr_d   = rr_q;
        st_d   = st_q;
        for (int unsigned j = 0; j < NUM_OUT; j++) begin
            if (lock_q[j]) begin
                if (axis_o_tvalid[j] && axis_o_tready[j] && axis_o_tlast[j]) begin
                    lock_d[j] = 1'b0;
                end
            end else if (win_vld[j]) begin
                lock_d[j] = 1'b1;
                gnt_d[j]  = win_idx[j];
                rr_d[j]   = win_idx[j];
            end
        end
        for (int unsigned k = 0; k < NUM_IN; k++) begin
            if (st_q[k] == ST_DROP) begin
                if (drop_fire[k]) begin
                    st_d[k] = ST_IDLE;
                end
            end else if (axis_i_tvalid[k] && !busy[k] && misroute[k]) begin
                st_d[k] = ST_DROP;
            end
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!sresetn) begin
            lock_q <= '0;
            for (int unsigned j = 0; j < NUM_OUT; j++) begin
                gnt_q[j] <= '0;
                rr_q[j]  <= GW'(NUM_IN - 1);
            end
            for (int unsigned k = 0; k < NUM_IN; k++) begin
                st_q[k] <= ST_IDLE;
            end
        end else begin
            lock_q <= lock_d;
            gnt_q  <= gnt_d;
            rr_q   <= rr_d;
            st_q   <= st_d;
        end
    end

`ifdef AXIS_SWITCH_DROP_CNT_EN
    logic [15:0] drop_cnt_q, drop_cnt_d;
    logic [16:0] drop_sum;

    // Add every discarded packet finishing this cycle, saturating at all-ones
    always_comb begin
        drop_sum = {1'b0, drop_cnt_q};
        for (int unsigned k = 0; k < NUM_IN; k++) begin
            if (drop_fire[k]) begin
                drop_sum = drop_sum + 17'd1;
            end
        end
        drop_cnt_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end

    // Drop counter register
    always_ff @(posedge clk) begin
        if (!sresetn) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_count = drop_cnt_q;
`endif

endmodule

// File: tb/tb_axis_switch_mxn.sv
// tb_axis_switch_mxn: directed cycle table for the corner cases followed by a
// randomized packet run checked against a per-input packet scoreboard.
module tb_axis_switch_mxn;

    logic        clk = 1'b0;
    logic        sresetn = 1'b0;
    logic [1:0]  iready;
    logic [1:0]  ivalid = '0;
    logic [1:0]  ilast = '0;
    logic [7:0]  idest = '0;
    logic [15:0] idata = '0;
    logic [3:0]  oready = '0;
    logic [3:0]  ovalid;
    logic [3:0]  olast;
    logic [15:0] odest;
    logic [31:0] odata;
`ifdef AXIS_SWITCH_DROP_CNT_EN
    logic [15:0] drop_count;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    axis_switch_mxn #(
        .AXIS_BYTES(1),
        .AXIS_TDEST_BITS(4),
        .NUM_IN(2),
        .NUM_OUT(4)
    ) dut (
        .clk(clk),
        .sresetn(sresetn),
        .axis_i_tready(iready),
        .axis_i_tvalid(ivalid),
        .axis_i_tlast(ilast),
        .axis_i_tdest(idest),
        .axis_i_tdata(idata),
        .axis_o_tready(oready),
        .axis_o_tvalid(ovalid),
        .axis_o_tlast(olast),
        .axis_o_tdest(odest),
        .axis_o_tdata(odata)
`ifdef AXIS_SWITCH_DROP_CNT_EN
        ,
        .drop_count(drop_count)
`endif
    );

    // ---------------- directed table ----------------
    typedef struct {
        logic        rstn;
        logic [1:0]  iv;
        logic [1:0]  il;
        logic [3:0]  id0;
        logic [3:0]  id1;
        logic [7:0]  d0;
        logic [7:0]  d1;
        logic [3:0]  ordy;
        logic [1:0]  e_ir;
        logic [3:0]  e_ov;
        logic [3:0]  e_ol;
        logic [31:0] e_od;
        int          e_dc;   // expected drop_count, -1 = not checked
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic rstn, input logic [1:0] iv, input logic [1:0] il,
                       input logic [3:0] id0, input logic [3:0] id1,
                       input logic [7:0] d0, input logic [7:0] d1, input logic [3:0] ordy,
                       input logic [1:0] e_ir, input logic [3:0] e_ov,
                       input logic [3:0] e_ol, input logic [31:0] e_od);
        vec_t v;
        v.rstn = rstn; v.iv = iv; v.il = il; v.id0 = id0; v.id1 = id1;
        v.d0 = d0; v.d1 = d1; v.ordy = ordy; v.e_ir = e_ir; v.e_ov = e_ov;
        v.e_ol = e_ol; v.e_od = e_od; v.e_dc = -1;
        tbl.push_back(v);
    endtask

    task automatic idle_row();
        add(1, 2'b00, 2'b00, 4'd0, 4'd0, 8'h00, 8'h00, 4'hF, 2'b00, 4'h0, 4'h0, 32'h0);
    endtask

    task automatic chk(input string name, input int row, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL row%0d %s: got %h expected %h", row, name, got, exp);
        end
    endtask

    // ---------------- random phase ----------------
    typedef struct {
        logic [7:0] data;
        logic       last;
        logic [3:0] dest;
    } beat_t;

    beat_t tx[2][$];    // beats each input will present
    beat_t exq[2][$];   // beats each input must deliver to some output
    int    owner[4];    // input currently mid-packet on each output, -1 = none
    int    rand_drops = 0;

    task automatic sb_check(input int j);
        int         k;
        bit         taken;
        bit         ok;
        logic [7:0] od;
        od = odata[j*8 +: 8];
        k  = owner[j];
        if (k < 0) begin
            for (int kk = 0; kk < 2; kk++) begin
                taken = 0;
                for (int jj = 0; jj < 4; jj++) if (owner[jj] == kk) taken = 1;
                if (!taken && exq[kk].size() > 0) begin
                    if (exq[kk][0].data == od) k = kk;
                end
            end
        end
        ok = 0;
        if (k >= 0) begin
            if (exq[k].size() > 0) begin
                ok = (exq[k][0].data == od) && (exq[k][0].last == olast[j]) &&
                     (exq[k][0].dest == 4'(j)) && (odest[j*4 +: 4] == 4'(j));
            end
        end
        checks++;
        if (!ok) begin
            errors++;
            if (k >= 0 && exq[k].size() > 0)
                $display("FAIL sb_out%0d: got data=%02h last=%0b dest=%0d expected data=%02h last=%0b dest=%0d",
                         j, od, olast[j], odest[j*4 +: 4], exq[k][0].data, exq[k][0].last, j);
            else
                $display("FAIL sb_out%0d: got data=%02h last=%0b, expected no beat (none pending)",
                         j, od, olast[j]);
        end else begin
            owner[j] = olast[j] ? -1 : k;
            void'(exq[k].pop_front());
        end
    endtask

    initial begin : main
        bit hs[2];
        int cyc;
        int r6;
        int len;
        logic [3:0] dv;
        logic [6:0] seq;
        beat_t b;

        // ---- directed rows: inputs, then expected iready/ovalid/olast/odata ----
        add(0, 2'b00, 2'b00, 4'd0, 4'd0, 8'h00, 8'h00, 4'hF, 2'b00, 4'h0, 4'h0, 32'h0);
        // 3-beat packet in0 -> out2
        add(1, 2'b01, 2'b00, 4'd2, 4'd0, 8'hA1, 8'h00, 4'hF, 2'b00, 4'h0, 4'h0, 32'h0);
        add(1, 2'b01, 2'b00, 4'd2, 4'd0, 8'hA1, 8'h00, 4'hF, 2'b01, 4'h4, 4'h0, 32'h00A10000);
        add(1, 2'b01, 2'b00, 4'd2, 4'd0, 8'hA2, 8'h00, 4'hF, 2'b01, 4'h4, 4'h0, 32'h00A20000);
        add(1, 2'b01, 2'b01, 4'd2, 4'd0, 8'hA3, 8'h00, 4'hF, 2'b01, 4'h4, 4'h4, 32'h00A30000);
        idle_row();
        // tie on out1 from reset pointer: in0, bubble, in1
        add(1, 2'b11, 2'b00, 4'd1, 4'd1, 8'hB0, 8'hC0, 4'hF, 2'b00, 4'h0, 4'h0, 32'h0);
        add(1, 2'b11, 2'b00, 4'd1, 4'd1, 8'hB0, 8'hC0, 4'hF, 2'b01, 4'h2, 4'h0, 32'h0000B000);
        add(1, 2'b11, 2'b01, 4'd1, 4'd1, 8'hB1, 8'hC0, 4'hF, 2'b01, 4'h2, 4'h2, 32'h0000B100);
        add(1, 2'b10, 2'b00, 4'd0, 4'd1, 8'h00, 8'hC0, 4'hF, 2'b00, 4'h0, 4'h0, 32'h0);
        add(1, 2'b10, 2'b00, 4'd0, 4'd1, 8'h00, 8'hC0, 4'hF, 2'b10, 4'h2, 4'h0, 32'h0000C000);
        add(1, 2'b10, 2'b10, 4'd0, 4'd1, 8'h00, 8'hC1, 4'hF, 2'b10, 4'h2, 4'h2, 32'h0000C100);
        // tie on out2 after in0 was last served there: in1 wins, single beats
        add(1, 2'b11, 2'b11, 4'd2, 4'd2, 8'hD0, 8'hE0, 4'hF, 2'b00, 4'h0, 4'h0, 32'h0);
        add(1, 2'b11, 2'b11, 4'd2, 4'd2, 8'hD0, 8'hE0, 4'hF, 2'b10, 4'h4, 4'h4, 32'h00E00000);
        add(1, 2'b01, 2'b01, 4'd2, 4'd0, 8'hD0, 8'h00, 4'hF, 2'b00, 4'h0, 4'h0, 32'h0);
        add(1, 2'b01, 2'b01, 4'd2, 4'd0, 8'hD0, 8'h00, 4'hF, 2'b01, 4'h4, 4'h4, 32'h00D00000);
        idle_row();
        // concurrent in0->out0, in1->out3 with out3 stalled 4 cycles
        add(1, 2'b11, 2'b00, 4'd0, 4'd3, 8'hF0, 8'h50, 4'hF, 2'b00, 4'h0, 4'h0, 32'h0);
        add(1, 2'b11, 2'b00, 4'd0, 4'd3, 8'hF0, 8'h50, 4'h7, 2'b01, 4'h9, 4'h0, 32'h500000F0);
        add(1, 2'b11, 2'b00, 4'd0, 4'd3, 8'hF1, 8'h50, 4'h7, 2'b01, 4'h9, 4'h0, 32'h500000F1);
        add(1, 2'b11, 2'b01, 4'd0, 4'd3, 8'hF2, 8'h50, 4'h7, 2'b01, 4'h9, 4'h1, 32'h500000F2);
        add(1, 2'b10, 2'b00, 4'd0, 4'd3, 8'h00, 8'h50, 4'h7, 2'b00, 4'h8, 4'h0, 32'h50000000);
        add(1, 2'b10, 2'b00, 4'd0, 4'd3, 8'h00, 8'h50, 4'hF, 2'b10, 4'h8, 4'h0, 32'h50000000);
        add(1, 2'b10, 2'b10, 4'd0, 4'd3, 8'h00, 8'h51, 4'hF, 2'b10, 4'h8, 4'h8, 32'h51000000);
        idle_row();
        // 4-beat packet to tdest=5 is discarded
        add(1, 2'b01, 2'b00, 4'd5, 4'd0, 8'h90, 8'h00, 4'hF, 2'b00, 4'h0, 4'h0, 32'h0);
        add(1, 2'b01, 2'b00, 4'd5, 4'd0, 8'h90, 8'h00, 4'hF, 2'b01, 4'h0, 4'h0, 32'h0);
        add(1, 2'b01, 2'b00, 4'd5, 4'd0, 8'h91, 8'h00, 4'hF, 2'b01, 4'h0, 4'h0, 32'h0);
        add(1, 2'b01, 2'b00, 4'd5, 4'd0, 8'h92, 8'h00, 4'hF, 2'b01, 4'h0, 4'h0, 32'h0);
        add(1, 2'b01, 2'b01, 4'd5, 4'd0, 8'h93, 8'h00, 4'hF, 2'b01, 4'h0, 4'h0, 32'h0);
        idle_row();
        tbl[tbl.size()-1].e_dc = 1;
        // tdest changes 2 -> 0 after grant; packet stays on out2
        add(1, 2'b01, 2'b00, 4'd2, 4'd0, 8'hA4, 8'h00, 4'hF, 2'b00, 4'h0, 4'h0, 32'h0);
        add(1, 2'b01, 2'b00, 4'd0, 4'd0, 8'hA4, 8'h00, 4'hF, 2'b01, 4'h4, 4'h0, 32'h00A40000);
        add(1, 2'b01, 2'b00, 4'd0, 4'd0, 8'hA5, 8'h00, 4'hF, 2'b01, 4'h4, 4'h0, 32'h00A50000);
        add(1, 2'b01, 2'b01, 4'd0, 4'd0, 8'hA6, 8'h00, 4'hF, 2'b01, 4'h4, 4'h4, 32'h00A60000);
        idle_row();
        // reset mid-packet, then tie on out2 must go to in0 again
        add(1, 2'b01, 2'b00, 4'd2, 4'd0, 8'hC5, 8'h00, 4'hF, 2'b00, 4'h0, 4'h0, 32'h0);
        add(1, 2'b01, 2'b00, 4'd2, 4'd0, 8'hC5, 8'h00, 4'hF, 2'b01, 4'h4, 4'h0, 32'h00C50000);
        add(0, 2'b11, 2'b00, 4'd2, 4'd2, 8'hC6, 8'hD6, 4'hF, 2'b00, 4'h0, 4'h0, 32'h0);
        add(1, 2'b11, 2'b11, 4'd2, 4'd2, 8'h31, 8'h41, 4'hF, 2'b00, 4'h0, 4'h0, 32'h0);
        tbl[tbl.size()-1].e_dc = 0;
        add(1, 2'b11, 2'b11, 4'd2, 4'd2, 8'h31, 8'h41, 4'hF, 2'b01, 4'h4, 4'h4, 32'h00310000);
        add(1, 2'b10, 2'b10, 4'd0, 4'd2, 8'h00, 8'h41, 4'hF, 2'b00, 4'h0, 4'h0, 32'h0);
        add(1, 2'b10, 2'b10, 4'd0, 4'd2, 8'h00, 8'h41, 4'hF, 2'b10, 4'h4, 4'h4, 32'h00410000);
        idle_row();

        for (int r = 0; r < tbl.size(); r++) begin
            @(posedge clk);
            #1;
            sresetn = tbl[r].rstn;
            ivalid  = tbl[r].iv;
            ilast   = tbl[r].il;
            idest   = {tbl[r].id1, tbl[r].id0};
            idata   = {tbl[r].d1, tbl[r].d0};
            oready  = tbl[r].ordy;
            @(negedge clk);
            chk("iready", r, 32'(iready), 32'(tbl[r].e_ir));
            chk("ovalid", r, 32'(ovalid), 32'(tbl[r].e_ov));
            chk("olast",  r, 32'(olast),  32'(tbl[r].e_ol));
            chk("odata",  r, odata, tbl[r].e_od);
`ifdef AXIS_SWITCH_DROP_CNT_EN
            if (tbl[r].e_dc >= 0) chk("drop_count", r, 32'(drop_count), 32'(tbl[r].e_dc));
`endif
        end

        // ---- randomized packets from both inputs ----
        for (int k = 0; k < 2; k++) begin
            seq = '0;
            for (int p = 0; p < 25; p++) begin
                r6  = $urandom_range(0, 6);
                dv  = (r6 == 6) ? 4'hF : 4'(r6);
                len = $urandom_range(1, 4);
                if (dv >= 4'd4) rand_drops++;
                for (int i = 0; i < len; i++) begin
                    b.data = {k[0], seq};
                    b.last = (i == len - 1);
                    b.dest = dv;
                    seq    = seq + 7'd1;
                    tx[k].push_back(b);
                    if (dv < 4'd4) exq[k].push_back(b);
                end
            end
        end
        for (int j = 0; j < 4; j++) owner[j] = -1;
        hs[0] = 0;
        hs[1] = 0;
        cyc   = 0;
        while (cyc < 20000) begin
            @(posedge clk);
            #1;
            for (int k = 0; k < 2; k++) begin
                if (hs[k]) begin
                    void'(tx[k].pop_front());
                    hs[k]     = 0;
                    ivalid[k] = 1'b0;
                end
            end
            if (tx[0].size() == 0 && tx[1].size() == 0) begin
                ivalid = '0;
                ilast  = '0;
                break;
            end
            for (int k = 0; k < 2; k++) begin
                if (tx[k].size() > 0) begin
                    if (!ivalid[k]) ivalid[k] = ($urandom_range(0, 3) != 0);
                    idata[k*8 +: 8] = tx[k][0].data;
                    ilast[k]        = tx[k][0].last;
                    idest[k*4 +: 4] = tx[k][0].dest;
                end else begin
                    ivalid[k] = 1'b0;
                    ilast[k]  = 1'b0;
                end
            end
            for (int j = 0; j < 4; j++) oready[j] = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            for (int j = 0; j < 4; j++) begin
                if (ovalid[j] && oready[j]) sb_check(j);
            end
            for (int k = 0; k < 2; k++) hs[k] = ivalid[k] && iready[k];
            cyc++;
        end

        checks++;
        if (cyc >= 20000) begin
            errors++;
            $display("FAIL rand_timeout: got %0d+%0d beats unsent after %0d cycles, expected 0",
                     tx[0].size(), tx[1].size(), cyc);
        end
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (exq[k].size() != 0) begin
                errors++;
                $display("FAIL rand_undelivered_in%0d: got %0d beats never seen, expected 0",
                         k, exq[k].size());
            end
        end
        @(negedge clk);
        checks++;
        if (ovalid !== 4'h0) begin
            errors++;
            $display("FAIL rand_idle_ovalid: got %b expected 0000", ovalid);
        end
`ifdef AXIS_SWITCH_DROP_CNT_EN
        chk("rand_drop_count", -1, 32'(drop_count), 32'(rand_drops));
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/axis_switch_mxn.md
Name: axis_switch_mxn

Overview:
- Packet-level AXI-Stream crossbar: NUM_IN slave streams, NUM_OUT master streams, routed by tdest.
- Each output has its own round-robin arbiter. A grant is held until the granted packet's tlast handshake.
- Packets with tdest >= NUM_OUT are consumed and discarded.
- Sits between packet sources (MACs, parsers) and per-destination consumers. Replaces the single-input tdest demux.

Parameters:
- AXIS_BYTES, 1, tdata width in bytes
- AXIS_TDEST_BITS, 4, tdest width
- NUM_IN, 2, number of input streams (>=1)
- NUM_OUT, 4, number of output streams (>=1, <= 2**AXIS_TDEST_BITS)

Ports:
- clk  in  1  clock
- sresetn  in  1  synchronous active-low reset
- axis_i_tready  out  NUM_IN  per-input ready
- axis_i_tvalid  in  NUM_IN  per-input valid
- axis_i_tlast  in  NUM_IN  per-input last
- axis_i_tdest  in  NUM_IN*AXIS_TDEST_BITS  packed, input k at [k*AXIS_TDEST_BITS +: AXIS_TDEST_BITS]
- axis_i_tdata  in  NUM_IN*AXIS_BYTES*8  packed as above
- axis_o_tready  in  NUM_OUT  per-output ready
- axis_o_tvalid  out  NUM_OUT  per-output valid
- axis_o_tlast  out  NUM_OUT  per-output last
- axis_o_tdest  out  NUM_OUT*AXIS_TDEST_BITS  tdest of granted input
- axis_o_tdata  out  NUM_OUT*AXIS_BYTES*8  tdata of granted input

Behaviour:
- One clock, clk. Reset sresetn is synchronous, active-low.
- Per-output state:
  - lock (1b)
  - gnt (index into NUM_IN)
  - rr_ptr (last granted input)
  - Reset values: lock=0, gnt=0, rr_ptr=NUM_IN-1, so input 0 wins the first tie.
- Per-input state: IDLE/DROP; reset value IDLE.
- While sresetn=0, all axis_o_tvalid=0 and all axis_i_tready=0.
- Reset mid-packet: all locks and drop states clear. The partial packet is abandoned; the upstream is responsible for recovery.
- Request: input k requests output j when:
  - k is IDLE
  - axis_i_tvalid[k]=1
  - tdest[k]==j
  - k is not currently granted anywhere
- Arbitration:
  - Applies to an unlocked output j with >=1 request.
  - Grant goes to the first requester searching rr_ptr+1, rr_ptr+2, ... (mod NUM_IN).
  - At the clock edge: lock<=1, gnt<=winner, rr_ptr<=winner.
- Latency: first beat appears on the output the cycle after the request (1 cycle). Zero-latency combinational pass-through while locked.
- Locked output j, granted input k:
  - axis_o_tvalid[j]=axis_i_tvalid[k]
  - tlast, tdest and tdata are copied from input k
  - axis_i_tready[k]=axis_o_tready[j]
- tdest is sampled only at grant. Changes to tdest mid-packet are ignored until tlast.
- Release: on the cycle with axis_o_tvalid[j] & axis_o_tready[j] & axis_o_tlast[j], lock<=0.
  - Output j is idle for exactly one cycle (bubble), then re-arbitrates.
- Unlocked output: axis_o_tvalid=0. tdata, tdest and tlast are don't-care; drive 0.
- An input that is neither granted nor dropping has axis_i_tready=0.
- Drop:
  - IDLE input with tvalid=1 and tdest>=NUM_OUT goes to DROP at the next edge.
  - In DROP: axis_i_tready=1; beats are discarded.
  - Return to IDLE on the tlast handshake.
- Simultaneous events:
  - Several inputs requesting different outputs are all granted in the same cycle.
  - Release and a new request on the same output in the same cycle: the request is served after the one-cycle bubble.
- Single-beat packets: grant, transfer, release. Minimum 2 cycles per packet per output.
- No starvation: with persistent requests, each requester is served within NUM_IN packets.

Optional Feature:
- Macro: AXIS_SWITCH_DROP_CNT_EN.
- Defined:
  - Adds output port drop_count out 16: saturating count of dropped packets.
  - Increments on each tlast handshake in DROP; holds at 16'hFFFF.
  - Reset to 0.
- Undefined:
  - Port absent, no counter logic.
  - Drop behaviour is unchanged.

Test Plan:
- NUM_IN=2, NUM_OUT=4. In0 sends 3-beat packet tdest=2, data 0xA1,0xA2,0xA3, all readies 1 -> out2 tvalid from cycle t+1, beats in order, tlast on 0xA3; out0/1/3 tvalid stay 0.
- In0 and in1 both send 2-beat packets to tdest=1 in the same cycle after reset -> in0 packet first, 1 bubble cycle, then in1. Repeat -> in1 first (round-robin).
- In0 to tdest=0, in1 to tdest=3 in the same cycle -> both granted at t+1 and transfer concurrently. Hold out3 tready=0 for 4 cycles -> in1 tready=0 for those cycles; in0 unaffected.
- In0 sends 4-beat packet tdest=5 -> in0 tready=1 from t+1, nothing appears on any output. With AXIS_SWITCH_DROP_CNT_EN, drop_count goes 0->1.
- Change in0 tdest from 2 to 0 mid-packet -> all beats still on out2.
- Deassert sresetn mid-packet for 1 cycle -> all tvalid/tready 0 that cycle. A fresh packet afterwards routes normally with rr_ptr reset (input 0 wins the tie).
